// File: rtl/rule30_cipher_ctrl.sv
// rule30_cipher_ctrl
// Byte-stream XOR cipher whose keystream is an 8-cell Rule-30 cellular
// automaton on a ring. A session starts from a stored seed, discards WARMUP
// key evolutions, then XORs each accepted byte with the current key and
// evolves the key once per accepted byte. Encryption and decryption are the
// same operation.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, stop          one-cycle session begin / end pulses
//   seed_load, seed_in   write the seed register (IDLE only; zero -> SEED)
//   in_valid, in_data    input byte handshake; in_ready when accepted
//   out_valid, out_data  registered XOR result; out_ready from downstream
//   key_out              current key register
//   busy                 session active (state not IDLE)
//   byte_count           bytes accepted this session (wraps)
module rule30_cipher_ctrl #(
  parameter logic [7:0]  SEED   = 8'b0001_1000,
  parameter logic [7:0]  RULE   = 8'b0001_1110,
  parameter int unsigned WARMUP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       seed_load,
  input  logic [7:0] seed_in,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [7:0] key_out,
  output logic       busy,
  output logic [7:0] byte_count
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWarm  = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic [3:0] WarmupCnt = 4'(WARMUP);

  logic [1:0] state_q, state_d;
  logic [7:0] key_q, key_d;
  logic [7:0] seed_q, seed_d;
  logic [3:0] warm_cnt_q, warm_cnt_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic [7:0] count_q, count_d;
  logic [7:0] key_next;
  logic       accept;

  // Rule lookup: neighbourhood {left, self, right} with ring wrap-around.
  always_comb begin
    key_next = '0;
    for (int i = 0; i < 8; i++) begin
      key_next[i] = RULE[{key_q[(i + 7) % 8], key_q[i], key_q[(i + 1) % 8]}];
    end
  end

  assign in_ready = (state_q == StRun) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    seed_d      = seed_q;
    warm_cnt_d  = warm_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q;

    case (state_q)
      StIdle: begin
        if (seed_load) begin
          seed_d = (seed_in == 8'h00) ? SEED : seed_in;
        end
        // seed_d already carries a same-cycle seed_load.
        if (start) begin
          key_d      = seed_d;
          count_d    = 8'h00;
          warm_cnt_d = WarmupCnt;
          state_d    = (WarmupCnt == 4'd0) ? StRun : StWarm;
        end
      end
      StWarm: begin
        key_d      = key_next;
        warm_cnt_d = warm_cnt_q - 4'd1;
        if (warm_cnt_q == 4'd1) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!out_valid_q || out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Output slot: an accept reloads it, otherwise a consume empties it.
    if (accept) begin
      out_data_d  = in_data ^ key_q;
      out_valid_d = 1'b1;
      key_d       = key_next;
      count_d     = count_q + 8'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      key_q       <= SEED;
      seed_q      <= SEED;
      warm_cnt_q  <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      count_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      seed_q      <= seed_d;
      warm_cnt_q  <= warm_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign key_out    = key_q;
  assign busy       = (state_q != StIdle);
  assign byte_count = count_q;

endmodule

// File: tb/tb_rule30_cipher_ctrl.sv
module tb_rule30_cipher_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, seed_load, in_valid, out_ready;
  logic [7:0] seed_in, in_data;

  logic       in_ready, out_valid, busy;
  logic [7:0] out_data, key_out, byte_count;
  logic       in_ready1, out_valid1, busy1;
  logic [7:0] out_data1, key_out1, byte_count1;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rule30_cipher_ctrl #(.SEED(8'h18), .RULE(8'h1E), .WARMUP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .seed_load(seed_load), .seed_in(seed_in),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .key_out(key_out), .busy(busy), .byte_count(byte_count)
  );

  rule30_cipher_ctrl #(.SEED(8'h18), .RULE(8'h1E), .WARMUP(0)) dut_w0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .seed_load(seed_load), .seed_in(seed_in),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
    .key_out(key_out1), .busy(busy1), .byte_count(byte_count1)
  );

  typedef struct {
    logic       start, stop, in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       e_busy, e_in_ready, e_out_valid;
    logic [7:0] e_out_data, e_key, e_count;
  } vec_t;

  // Rule 30 reference: new[i] = 1 for neighbourhood values 1..4.
  function automatic logic [7:0] nk(input logic [7:0] k);
    logic [7:0] r;
    int         n;
    for (int i = 0; i < 8; i++) begin
      n    = {29'd0, k[(i + 7) % 8], k[i], k[(i + 1) % 8]};
      r[i] = (n >= 1) && (n <= 4);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Waits for the falling edge, drives inputs, and settles before checks.
  task automatic drv(input logic st, input logic sp, input logic iv,
                     input logic [7:0] id, input logic ordy);
    @(negedge clk);
    start = st; stop = sp; in_valid = iv; in_data = id; out_ready = ordy;
    seed_load = 1'b0; seed_in = 8'h00;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 0; stop = 0; seed_load = 0; seed_in = 0; in_valid = 0; in_data = 0;
    out_ready = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t       tbl[7];
  logic [7:0] pt[4];
  logic [7:0] ct[4];
  logic [7:0] mk;

  initial begin
    rst = 1'b1;
    start = 0; stop = 0; seed_load = 0; seed_in = 0; in_valid = 0; in_data = 0;
    out_ready = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_key", key_out, 8'h18);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_out", {7'd0, out_valid}, 8'd0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_count", byte_count, 8'h00);
    rst = 1'b0;

    //        st sp iv data   ordy  busy rdy ov  odata  key    cnt
    tbl[0] = '{1, 0, 0, 8'h00, 0,   0,   0,  0,  8'h00, 8'h18, 8'h00};
    tbl[1] = '{0, 0, 1, 8'h77, 1,   1,   0,  0,  8'h00, 8'h18, 8'h00};
    tbl[2] = '{0, 0, 0, 8'h00, 1,   1,   0,  0,  8'h00, 8'h2C, 8'h00};
    tbl[3] = '{0, 0, 1, 8'hA5, 1,   1,   1,  0,  8'h00, 8'h66, 8'h00};
    tbl[4] = '{0, 0, 1, 8'hFF, 1,   1,   1,  1,  8'hC3, 8'hBB, 8'h01};
    tbl[5] = '{0, 0, 0, 8'h00, 1,   1,   1,  1,  8'h44, 8'h88, 8'h02};
    tbl[6] = '{1, 0, 0, 8'h00, 1,   1,   1,  0,  8'h44, 8'h88, 8'h02};

    for (int v = 0; v < 7; v++) begin
      drv(tbl[v].start, tbl[v].stop, tbl[v].in_valid, tbl[v].in_data, tbl[v].out_ready);
      chk($sformatf("v%0d_busy", v), {7'd0, busy}, {7'd0, tbl[v].e_busy});
      chk($sformatf("v%0d_in_ready", v), {7'd0, in_ready}, {7'd0, tbl[v].e_in_ready});
      chk($sformatf("v%0d_out_valid", v), {7'd0, out_valid}, {7'd0, tbl[v].e_out_valid});
      chk($sformatf("v%0d_out_data", v), out_data, tbl[v].e_out_data);
      chk($sformatf("v%0d_key", v), key_out, tbl[v].e_key);
      chk($sformatf("v%0d_count", v), byte_count, tbl[v].e_count);
    end

    // Backpressure: one byte accepted, held stable for 5 stalled cycles.
    drv(0, 0, 1, 8'h12, 0);
    chk("stall_first_ready", {7'd0, in_ready}, 8'd1);
    for (int c = 0; c < 5; c++) begin
      drv(0, 0, 1, 8'h34, 0);
      chk("stall_ready", {7'd0, in_ready}, 8'd0);
      chk("stall_valid", {7'd0, out_valid}, 8'd1);
      chk("stall_data", out_data, 8'h12 ^ 8'h88);
      chk("stall_count", byte_count, 8'h03);
    end
    drv(0, 0, 0, 8'h00, 1);
    chk("stall_release_ready", {7'd0, in_ready}, 8'd1);
    drv(0, 0, 0, 8'h00, 0);
    chk("stall_drop_valid", {7'd0, out_valid}, 8'd0);
    mk = nk(8'h88);
    chk("stall_key", key_out, mk);

    // Stop with a same-cycle transfer, then drain under backpressure.
    drv(0, 1, 1, 8'h00, 0);
    for (int c = 0; c < 3; c++) begin
      drv(0, 0, 1, 8'h55, 0);
      chk("drain_busy", {7'd0, busy}, 8'd1);
      chk("drain_ready", {7'd0, in_ready}, 8'd0);
      chk("drain_valid", {7'd0, out_valid}, 8'd1);
      chk("drain_data", out_data, mk);
      chk("drain_key", key_out, nk(mk));
    end
    drv(0, 0, 0, 8'h00, 1);
    drv(0, 0, 0, 8'h00, 0);
    chk("drain_idle_busy", {7'd0, busy}, 8'd0);
    chk("drain_idle_valid", {7'd0, out_valid}, 8'd0);
    chk("drain_count", byte_count, 8'h04);

    // Encrypt four bytes against the reference keystream.
    pt[0] = 8'h48; pt[1] = 8'h69; pt[2] = 8'h21; pt[3] = 8'h00;
    do_reset();
    drv(1, 0, 0, 8'h00, 1);
    drv(0, 0, 0, 8'h00, 1);
    drv(0, 0, 0, 8'h00, 1);
    mk = nk(nk(8'h18));
    for (int k = 0; k < 4; k++) begin
      drv(0, 0, 1, pt[k], 1);
      if (k > 0) chk($sformatf("enc%0d", k - 1), out_data, ct[k - 1]);
      ct[k] = pt[k] ^ mk;
      mk    = nk(mk);
    end
    drv(0, 0, 0, 8'h00, 1);
    chk("enc3", out_data, ct[3]);

    // Decrypt with a fresh session from the same seed.
    do_reset();
    drv(1, 0, 0, 8'h00, 1);
    drv(0, 0, 0, 8'h00, 1);
    drv(0, 0, 0, 8'h00, 1);
    for (int k = 0; k < 4; k++) begin
      drv(0, 0, 1, ct[k], 1);
      if (k > 0) chk($sformatf("dec%0d", k - 1), out_data, pt[k - 1]);
    end
    drv(0, 0, 1, 8'h00, 1);
    chk("dec3", out_data, pt[3]);
    chk("dec_count", byte_count, 8'h04);

    // 256 accepted bytes wrap the counter to zero.
    for (int k = 0; k < 251; k++) drv(0, 0, 1, 8'h00, 1);
    chk("count_ff", byte_count, 8'hFF);
    drv(0, 0, 0, 8'h00, 1);
    chk("count_wrap", byte_count, 8'h00);
    chk("wrap_busy", {7'd0, busy}, 8'd1);

    // Reset mid-session with a pending byte.
    drv(0, 0, 1, 8'hAA, 0);
    drv(0, 0, 1, 8'hAA, 0);
    chk("pre_rst_valid", {7'd0, out_valid}, 8'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", {7'd0, out_valid}, 8'd0);
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_key", key_out, 8'h18);
    chk("arst_ready", {7'd0, in_ready}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    drv(0, 0, 1, 8'hAA, 1);
    drv(0, 0, 1, 8'hAA, 1);
    chk("post_rst_idle", {7'd0, busy}, 8'd0);
    chk("post_rst_ready", {7'd0, in_ready}, 8'd0);

    // WARMUP=0 instance: zero seed replaced by SEED, start goes straight to RUN.
    do_reset();
    @(negedge clk);
    seed_load = 1; seed_in = 8'h00;
    @(negedge clk);
    seed_load = 0;
    drv(1, 0, 0, 8'h00, 1);
    drv(0, 0, 0, 8'h00, 1);
    chk("w0_key", key_out1, 8'h18);
    chk("w0_busy", {7'd0, busy1}, 8'd1);
    chk("w0_ready", {7'd0, in_ready1}, 8'd1);

    // Same-cycle seed_load and start uses the new seed.
    do_reset();
    @(negedge clk);
    seed_load = 1; seed_in = 8'h5A; start = 1;
    @(negedge clk);
    seed_load = 0; start = 0;
    #1;
    chk("w0_seed_start_key", key_out1, 8'h5A);
    chk("seed_start_key", key_out, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
